// File: rtl/pipe_skid_register_pkg.sv
// Shared definitions for the pipeline skid register: occupancy state encodings
// and the default datapath width.
package pipe_skid_register_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipe_state_e;

endpackage : pipe_skid_register_pkg

// File: rtl/pipe_skid_register_data.sv
// N-bit storage register with load enable and synchronous active-high reset
// to a parameterised value; used for both the main and the skid entry.
module data_register #(
  parameter int            N           = 64,
  parameter logic [N-1:0]  RESET_VALUE = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  // Storage update: reset wins over load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule : data_register

// File: rtl/pipe_skid_register.sv
// Valid/ready pipeline register with a one-entry skid buffer. Handshake outputs
// decode only the registered state, so out_ready never reaches in_ready.
module pipe_skid_register
  import pipe_skid_register_pkg::*;
#(
  parameter int            N           = XLEN,
  parameter logic [N-1:0]  RESET_VALUE = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out
);

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_main_load;
  logic         w_skid_load;
  logic         w_main_from_skid;
  logic [N-1:0] w_main_d;
  logic [N-1:0] w_skid_q;

  assign out_valid  = (r_state == PIPE_ONE) || (r_state == PIPE_TWO);
  assign in_ready   = (r_state != PIPE_TWO);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_main_d   = w_main_from_skid ? w_skid_q : data_in;

  // Occupancy next-state and the register load controls it implies.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      PIPE_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_state_nxt = PIPE_ONE;
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = PIPE_TWO;
          w_skid_load = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = PIPE_EMPTY;
        end else begin
          w_state_nxt = PIPE_ONE;
        end
      end
      PIPE_TWO: begin
        if (w_out_fire) begin
          w_state_nxt      = PIPE_ONE;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end else begin
          w_state_nxt = PIPE_TWO;
        end
      end
      default: begin
        // EMPTY, and the unused encoding 3 which is folded back into EMPTY.
        if (w_in_fire) begin
          w_state_nxt = PIPE_ONE;
          w_main_load = 1'b1;
        end else begin
          w_state_nxt = PIPE_EMPTY;
        end
      end
    endcase
  end

  // State register: reset over flush over handshake update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PIPE_EMPTY;
    end else if (flush) begin
      r_state <= PIPE_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A flush leaves stored data untouched so data_out keeps its last value.
  data_register #(.N(N), .RESET_VALUE(RESET_VALUE)) u_main (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_main_load & ~flush),
    .i_d    (w_main_d),
    .o_q    (data_out)
  );

  data_register #(.N(N), .RESET_VALUE(RESET_VALUE)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_skid_load & ~flush),
    .i_d    (data_in),
    .o_q    (w_skid_q)
  );

endmodule : pipe_skid_register

// File: doc/pipe_skid_register.md
Name: pipe_skid_register

Overview:
- Parametrised N-bit pipeline register with a valid/ready handshake and a one-entry skid buffer.
- Separates adjacent RISC-V pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Sustains one transfer per cycle with no combinational path from out_ready to in_ready.
- Supports a synchronous flush for branch mispredict and trap squash.

Parameters:
- N, 64: data width in bits.
- RESET_VALUE, 0: N-bit value loaded into both data registers on reset.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high; clears all state.
- flush, input, 1: synchronous squash; discards all buffered entries.
- in_valid, input, 1: producer has data_in available.
- in_ready, output, 1: block accepts data this cycle.
- data_in, input, N: producer data.
- out_valid, output, 1: data_out holds a valid entry.
- out_ready, input, 1: consumer accepts data_out this cycle.
- data_out, output, N: oldest buffered entry.

Behaviour:
- Single clock clk. Reset is synchronous and active-high (port reset); polarity and synchronicity are fixed.
- Storage: main register (drives data_out) and skid register, both N bits.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- States (2-bit encoding):
  - EMPTY = 0: no entries.
  - ONE = 1: main valid.
  - TWO = 2: main and skid valid.
- Outputs are decoded from registered state only:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
- Transitions on the clk rising edge (reset and flush inactive):
  - EMPTY, in_fire -> ONE; main <= data_in.
  - ONE, in_fire & out_fire -> ONE; main <= data_in.
  - ONE, in_fire & !out_fire -> TWO; skid <= data_in.
  - ONE, !in_fire & out_fire -> EMPTY.
  - TWO, out_fire -> ONE; main <= skid. in_ready is 0, so nothing is accepted.
  - All other combinations: hold state and data.
- Latency: data accepted in cycle t appears on data_out in cycle t+1. Throughput is 1 entry/cycle while out_ready = 1.
- Ordering: strict FIFO. Entries are never dropped or duplicated.
- Reset:
  - state <= EMPTY; main <= RESET_VALUE; skid <= RESET_VALUE.
  - After reset, out_valid = 0, in_ready = 1, data_out = RESET_VALUE.
- Flush:
  - state <= EMPTY; main and skid keep their contents, so data_out is unchanged but out_valid = 0.
  - An in_fire in the same cycle as flush is discarded.
  - An out_fire in the same cycle completes normally for the consumer.
- Priority: reset > flush > handshake update.
- Reset or flush asserted mid-operation (state ONE or TWO) empties the block on the next edge regardless of in_valid/out_ready.
- data_out is not defined as meaningful while out_valid = 0. It holds the last main value, and the bench must not check it then.
- in_valid asserted while in_ready = 0 has no effect. The producer must hold data_in.
- Any invalid state encoding (3) behaves as EMPTY.
- No initial blocks are relied on for function; reset defines all state.

Decomposition:
- Shared package/include holds:
  - State encodings: PIPE_EMPTY = 2'd0, PIPE_ONE = 2'd1, PIPE_TWO = 2'd2.
  - Default widths: XLEN = 64.
- One natural sub-module: data_register, an N-bit register with load enable, synchronous active-high reset to RESET_VALUE.
  - Instantiated twice, as main and skid.
  - Load enables and input mux are driven by the state logic in pipe_skid_register.

Test Plan:
- Reset: hold reset 2 cycles with in_valid = 1, data_in = 0xAAAA -> out_valid = 0, in_ready = 1, data_out = RESET_VALUE (0) after release.
- Streaming: out_ready = 1; send 0x1, 0x2, 0x3 on consecutive cycles -> data_out = 0x1, 0x2, 0x3 on the following consecutive cycles, in_ready = 1 throughout.
- Backpressure and skid:
  - out_ready = 0; send 0x10 then 0x20 -> state TWO, in_ready = 0, data_out = 0x10.
  - A third word 0x30 is held by the producer.
  - Raise out_ready -> outputs 0x10, 0x20, 0x30 in order, none lost.
- Flush: in state TWO (0x10, 0x20) assert flush with in_valid = 1, data_in = 0x99 -> next cycle out_valid = 0, in_ready = 1. 0x99 is never output.
- Simultaneous: state ONE holding 0x5; in_fire with 0x6 and out_fire in the same cycle -> state stays ONE, data_out = 0x6 next cycle.
- Priority: assert reset and flush together while in state ONE -> state EMPTY, data_out = RESET_VALUE. Repeat with N = 32 and RESET_VALUE = 0x13 (NOP) -> data_out = 0x13.
